// File: rtl/epb_strip_pack_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | epb_strip_pack_if: byte-word stream in/out of the EPB stripper  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface epb_strip_pack_if #(
  parameter int LANES = 2
) ();
  localparam int NB_W = $clog2(LANES + 1);

  logic                 in_valid;
  logic [8*LANES-1:0]   in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [8*LANES-1:0]   out_data;
  logic [NB_W-1:0]      out_nbytes;
  logic                 out_last;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nbytes, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nbytes, out_last
  );
endinterface
`default_nettype wire

// File: rtl/epb_strip_pack.sv
`default_nettype none
// +----------------------------------------------------------------+
// | epb_strip_pack: drops 00 00 03 emulation-prevention bytes and   |
// | repacks the survivors into dense words.  Rev 1.0                |
// +----------------------------------------------------------------+
module epb_strip_pack #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bypass,
  epb_strip_pack_if.slave  bus,
  output logic [CNT_W-1:0] epb_count
);
  localparam int BUF_B  = 2 * LANES - 1;
  localparam int BUF_W  = 8 * BUF_B;
  localparam int FILL_W = $clog2(2 * LANES);
  localparam int NB_W   = $clog2(LANES + 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [FILL_W-1:0] C_LANES = FILL_W'(LANES);

  logic [0:0]        r_state, w_state_n;
  logic [1:0]        r_zrun, w_zrun_n;
  logic [FILL_W-1:0] r_fill, w_fill_n;
  logic [BUF_W-1:0]  r_buf, w_buf_n;
  logic              r_new_nal, w_new_nal_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic [NB_W-1:0]   w_ndrop;
  logic              w_accept, w_pop;
  logic              w_valid_n, w_last_n;
  logic [NB_W-1:0]   w_nb_n;

  assign bus.in_ready = (r_state == S_RUN) && ((r_fill < C_LANES) || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pop        = bus.out_valid && bus.out_ready;

  always_comb begin
    logic [7:0]       b;
    logic [1:0]       z;
    int               pos;
    logic [CNT_W-1:0] base;
    logic [CNT_W:0]   sum;
    b           = '0;
    z           = r_zrun;
    pos         = 0;
    base        = '0;
    sum         = '0;
    w_buf_n     = r_buf;
    w_fill_n    = r_fill;
    w_zrun_n    = r_zrun;
    w_ndrop     = '0;
    w_state_n   = r_state;
    w_new_nal_n = r_new_nal;
    w_cnt_n     = epb_count;

    // Pop first so an append in the same cycle lands behind the survivors.
    if (w_pop) begin
      if (bus.out_last) begin
        w_buf_n     = '0;
        w_fill_n    = '0;
        w_state_n   = S_RUN;
        w_new_nal_n = 1'b1;
      end else begin
        w_buf_n  = r_buf << (8 * LANES);
        w_fill_n = r_fill - C_LANES;
      end
    end

    if (w_accept) begin
      pos = int'(w_fill_n);
      for (int i = 0; i < LANES; i++) begin
        b = bus.in_data[8*(LANES-1-i) +: 8];
        if (!bypass && z == 2'd2 && b == 8'h03) begin
          z       = 2'd0;
          w_ndrop = w_ndrop + NB_W'(1);
        end else begin
          z = (b == 8'h00) ? ((z == 2'd2) ? 2'd2 : z + 2'd1) : 2'd0;
          if (pos < BUF_B) begin
            w_buf_n[BUF_W-8-8*pos +: 8] = b;
          end
          pos = pos + 1;
        end
      end
      w_fill_n    = FILL_W'(pos);
      w_zrun_n    = bus.in_last ? 2'd0 : z;
      if (bus.in_last) begin
        w_state_n = S_DRAIN;
      end
      base        = w_new_nal_n ? '0 : epb_count;
      sum         = {1'b0, base} + (CNT_W+1)'(w_ndrop);
      w_cnt_n     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      w_new_nal_n = 1'b0;
    end

    // Output word is a function of the post-update buffer, registered below.
    if (w_state_n == S_RUN) begin
      w_valid_n = (w_fill_n >= C_LANES);
      w_last_n  = 1'b0;
      w_nb_n    = w_valid_n ? NB_W'(LANES) : '0;
    end else begin
      w_valid_n = 1'b1;
      if (w_fill_n > C_LANES) begin
        w_last_n = 1'b0;
        w_nb_n   = NB_W'(LANES);
      end else begin
        w_last_n = 1'b1;
        w_nb_n   = NB_W'(w_fill_n);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_RUN;
      r_zrun         <= '0;
      r_fill         <= '0;
      r_buf          <= '0;
      r_new_nal      <= 1'b1;
      epb_count      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_nbytes <= '0;
      bus.out_data   <= '0;
    end else begin
      r_state        <= w_state_n;
      r_zrun         <= w_zrun_n;
      r_fill         <= w_fill_n;
      r_buf          <= w_buf_n;
      r_new_nal      <= w_new_nal_n;
      epb_count      <= w_cnt_n;
      bus.out_valid  <= w_valid_n;
      bus.out_last   <= w_last_n;
      bus.out_nbytes <= w_nb_n;
      bus.out_data   <= w_buf_n[BUF_W-1 -: 8*LANES];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_epb_strip_pack.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_epb_strip_pack: scoreboard bench, LANES=2 and LANES=4 DUTs   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_epb_strip_pack;
  typedef struct {
    logic [31:0] data;
    int          nb;
    bit          last;
    int          cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        byp2, byp4;
  logic [15:0] cnt2;
  logic [1:0]  cnt4;
  bit          rnd;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_z[2];
  int          m_cnt[2];
  bit          m_new[2];
  int          c_max[2];
  int          lasts_in[2];
  int          lasts_out[2];
  logic [7:0]  m_pend[2][$];
  exp_t        m_exp[2][$];

  epb_strip_pack_if #(.LANES(2)) b2 ();
  epb_strip_pack_if #(.LANES(4)) b4 ();

  epb_strip_pack #(.LANES(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .bypass(byp2), .bus(b2.slave), .epb_count(cnt2)
  );
  // Narrow counter on the 4-lane instance exposes saturation.
  epb_strip_pack #(.LANES(4), .CNT_W(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .bypass(byp4), .bus(b4.slave), .epb_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic emit(input int k, input int lanes, input int n, input bit last);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[8*(lanes-1-i) +: 8] = m_pend[k].pop_front();
    e.nb   = n;
    e.last = last;
    e.cnt  = m_cnt[k];
    m_exp[k].push_back(e);
  endtask

  task automatic model_word(input int k, input int lanes, input logic [31:0] d,
                            input bit last, input bit byp);
    logic [7:0] b;
    if (m_new[k]) begin
      m_cnt[k] = 0;
      m_new[k] = 1'b0;
    end
    for (int i = 0; i < lanes; i++) begin
      b = d[8*(lanes-1-i) +: 8];
      if (!byp && m_z[k] == 2 && b == 8'h03) begin
        m_z[k] = 0;
        if (m_cnt[k] < c_max[k]) m_cnt[k]++;
      end else begin
        m_z[k] = (b == 8'h00) ? ((m_z[k] < 2) ? m_z[k] + 1 : 2) : 0;
        m_pend[k].push_back(b);
      end
    end
    while (m_pend[k].size() > lanes || (!last && m_pend[k].size() == lanes))
      emit(k, lanes, lanes, 1'b0);
    if (last) begin
      emit(k, lanes, m_pend[k].size(), 1'b1);
      m_z[k]   = 0;
      m_new[k] = 1'b1;
    end
  endtask

  task automatic send(input int k, input logic [31:0] d, input bit last);
    int t;
    bit acc;
    t   = 0;
    acc = 1'b0;
    if (k == 0) begin
      b2.in_valid = 1'b1; b2.in_data = d[15:0]; b2.in_last = last;
    end else begin
      b4.in_valid = 1'b1; b4.in_data = d; b4.in_last = last;
    end
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = (k == 0) ? b2.in_ready : b4.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    else begin
      model_word(k, (k == 0) ? 2 : 4, d, last, (k == 0) ? byp2 : byp4);
      if (last) lasts_in[k]++;
    end
    if (k == 0) b2.in_valid = 1'b0;
    else        b4.in_valid = 1'b0;
  endtask

  task automatic mon(input int k, input string p, input bit v, input bit r,
                     input logic [31:0] d, input logic [31:0] nb, input bit l,
                     input bit ir, input logic [31:0] cnt);
    exp_t e;
    if (lasts_in[k] > lasts_out[k]) chk({p, "_drain_in_ready"}, 32'(ir), 32'd0);
    if (v && r) begin
      if (m_exp[k].size() == 0) chk({p, "_unexpected_word"}, 32'd1, 32'd0);
      else begin
        e = m_exp[k].pop_front();
        chk({p, "_data"}, d, e.data);
        chk({p, "_nbytes"}, nb, 32'(e.nb));
        chk({p, "_last"}, 32'(l), 32'(e.last));
        if (e.last) chk({p, "_epb_count"}, cnt, 32'(e.cnt));
      end
      if (l) lasts_out[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, "L2", b2.out_valid, b2.out_ready, 32'(b2.out_data), 32'(b2.out_nbytes),
          b2.out_last, b2.in_ready, 32'(cnt2));
      mon(1, "L4", b4.out_valid, b4.out_ready, 32'(b4.out_data), 32'(b4.out_nbytes),
          b4.out_last, b4.in_ready, 32'(cnt4));
    end
  end

  initial begin
    b2.out_ready = 1'b1;
    b4.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b2.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      b4.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0, 1:    return 8'h00;
      2:       return 8'h03;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int len;
    int t;
    logic [31:0] w;
    reset_n = 1'b0;
    byp2 = 1'b0; byp4 = 1'b0; rnd = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_z[k] = 0; m_cnt[k] = 0; m_new[k] = 1'b1; lasts_in[k] = 0; lasts_out[k] = 0;
    end
    c_max[0] = 65535;
    c_max[1] = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("rst_out_data", 32'(b2.out_data), 32'd0);
    chk("rst_out_nbytes", 32'(b2.out_nbytes), 32'd0);
    chk("rst_out_last", 32'(b2.out_last), 32'd0);
    chk("rst_epb_count", 32'(cnt2), 32'd0);
    chk("rst_in_ready", 32'(b2.in_ready), 32'd1);
    chk("rst_l4_out_valid", 32'(b4.out_valid), 32'd0);
    reset_n = 1'b1;

    // Directed streams, no backpressure.
    send(0, 32'h0000, 0); send(0, 32'h0301, 0); send(0, 32'h0203, 1);
    send(0, 32'h0000, 0); send(0, 32'h0300, 0); send(0, 32'h0003, 0); send(0, 32'h0305, 1);
    send(0, 32'h0000, 0); send(0, 32'h0303, 1);
    byp2 = 1'b1;
    send(0, 32'h0000, 0); send(0, 32'h0301, 0); send(0, 32'h0203, 1);
    byp2 = 1'b0;
    send(1, 32'h00000300, 0); send(1, 32'h00030A0B, 1);
    send(1, 32'h03030303, 1);

    // NAL boundary under random backpressure: zrun must not carry over.
    rnd = 1'b1;
    send(0, 32'h0000, 1); send(0, 32'h0301, 1);
    send(1, 32'h00000000, 1); send(1, 32'h03000003, 1);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        w = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
        byp2 = ($urandom_range(0, 7) == 0);
        byp4 = ($urandom_range(0, 7) == 0);
        send(n % 2, (n % 2 == 0) ? {16'h0, w[15:0]} : w, i == len - 1);
      end
    end
    // Dense EPB stream on the 4-lane instance drives its 2-bit counter to saturation.
    byp4 = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 32'h00000300, i == 3);

    t = 0;
    while ((m_exp[0].size() != 0 || m_exp[1].size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_empty", 32'(m_exp[0].size() + m_exp[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
